dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the pipeline's memory/branch stage (CPU port) and a second requester (DMA/loader port) with a valid/ready handshake. Sits between the mem-stage store encoder and the dmem array. It grants at most one access per cycle, stalls the pipeline when the CPU loses arbitration, and returns synchronous read data to the port that issued the read. The CPU has fixed priority, bounded by a starvation counter that guarantees DMA progress.

## Interface
- ADDR_W, 11, word-address width (dmem addr[12:2])
- STARVE_MAX, 4, consecutive cycles a waiting DMA request may be denied before it is force-granted; legal range 1..255
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_flush  in  1  kills the current mem-stage access
- cpu_read  in  1  CPU load request
- cpu_writeb  in  4  CPU byte write enables (already encoded)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU encoded store data
- cpu_stall  out  1  CPU request present but not granted this cycle
- cpu_rdata  out  32  read data, valid the cycle after a granted CPU read
- dma_valid  in  1  DMA request pending
- dma_ready  out  1  DMA request granted this cycle
- dma_we  in  1  1 = write, 0 = read
- dma_writeb  in  4  DMA byte enables (ignored when dma_we = 0)
- dma_addr  in  ADDR_W  DMA word address
- dma_wdata  in  32  DMA write data
- dma_rvalid  out  1  dma_rdata valid (one cycle after a granted DMA read)
- dma_rdata  out  32  DMA read data
- mem_read  out  1  to dmem read
- mem_writeb  out  4  to dmem writeb
- mem_addr  out  ADDR_W  to dmem addr
- mem_wdata  out  32  to dmem wdata
- mem_rdata  in  32  from dmem, registered, one-cycle latency

## Operation
- cpu_req = (cpu_read | |cpu_writeb) & !pipe_flush; a flushed access is never granted and never stalls.
- dma_req = dma_valid.
- Grant (combinational, per cycle):
  - cpu_req & !dma_req -> CPU.
  - dma_req & !cpu_req -> DMA.
  - both, starve_cnt < STARVE_MAX -> CPU; both, starve_cnt == STARVE_MAX -> DMA.
- cpu_stall = cpu_req & !grant_cpu; dma_ready = grant_dma.
- Mux: mem_* driven from granted port; no grant -> mem_read = 0, mem_writeb = 0, mem_addr/mem_wdata = CPU values (don't-care).
- DMA read: mem_read = 1, mem_writeb = 0. DMA write: mem_read = 0, mem_writeb = dma_writeb.
- starve_cnt (8-bit, saturating at STARVE_MAX): +1 when dma_req & !grant_dma; cleared on grant_dma or !dma_req.
- Read-owner FSM, states NONE / CPU / DMA, next state from this cycle's grant: granted read -> owner of that read; otherwise NONE. Every state may go to every other state each cycle.
- dma_rvalid = (owner == DMA); dma_rdata = mem_rdata. cpu_rdata = mem_rdata unconditionally (mem stage captures it only for its own loads).
- DMA handshake: the request is consumed only when dma_valid & dma_ready. The DMA port holds addr/data/we stable until dma_ready.

## Timing
- Grant, stall, dma_ready and mem_* are combinational from the same-cycle inputs and registered state; zero-cycle issue.
- Read latency: 1 cycle from grant to cpu_rdata/dma_rvalid.
- Back-to-back grants every cycle are allowed; owner pipelining supports alternating CPU/DMA reads with no bubble.
- Reset (rst_n low, async): starve_cnt = 0, owner = NONE, dma_rvalid = 0. While reset is held, grants are forced 0, so dma_ready = 0, cpu_stall = 0, mem_read = 0, mem_writeb = 0.
- Reset asserted with a read in flight: the read result is dropped and dma_rvalid does not pulse after release.
- pipe_flush in the same cycle as a DMA request: DMA is granted and starve_cnt clears.
- A CPU request continuously stalled by one forced DMA grant is re-granted the next cycle (starve_cnt = 0 gives CPU priority).

## Test plan
- CPU load only: cpu_read = 1, addr 0x010 -> mem_read = 1, mem_addr = 0x010, cpu_stall = 0; next cycle dma_rvalid = 0 and cpu_rdata = mem_rdata.
- DMA write only: dma_valid = 1, dma_we = 1, dma_writeb = 4'b1111, addr 0x7FF, data 0xDEADBEEF -> dma_ready = 1 same cycle, mem_writeb = 4'b1111, mem_wdata = 0xDEADBEEF.
- Contention with STARVE_MAX = 4: CPU and DMA both requesting continuously -> CPU granted cycles 0-3, DMA granted cycle 4 with cpu_stall = 1, CPU granted cycle 5; the pattern repeats with period 5.
- pipe_flush = 1 with cpu_writeb = 4'b0011 and no DMA request -> mem_writeb = 0, cpu_stall = 0.
- Alternating reads (DMA addr 0x004 then CPU addr 0x008, consecutive cycles) -> dma_rvalid pulses exactly one cycle, in the cycle after the DMA grant; owner goes DMA then CPU.
- Reset mid-read: DMA read granted, rst_n pulled low before the next edge -> dma_rvalid stays 0, starve_cnt = 0, and no grants until rst_n rises.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU mem stage vs DMA port, fixed CPU priority
// with a starvation bound, plus read-data ownership tracking.
module dmem_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_flush,
   input  logic              cpu_read,
   input  logic [3:0]        cpu_writeb,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic [31:0]       cpu_rdata,
   input  logic              dma_valid,
   output logic              dma_ready,
   input  logic              dma_we,
   input  logic [3:0]        dma_writeb,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_rvalid,
   output logic [31:0]       dma_rdata,
   output logic              mem_read,
   output logic [3:0]        mem_writeb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_DMA  = 2'd2;
   localparam logic [7:0] SMAX     = 8'(STARVE_MAX);

   logic [7:0] starve_cnt;
   logic [1:0] owner;
   logic [1:0] owner_nxt;
   logic       cpu_req;
   logic       dma_req;
   logic       dma_first;
   logic       grant_cpu;
   logic       grant_dma;

   assign cpu_req   = (cpu_read | (|cpu_writeb)) & ~pipe_flush;
   assign dma_req   = dma_valid;
   assign dma_first = (starve_cnt >= SMAX);

   // rst_n gates grants so nothing reaches memory while reset is held
   assign grant_cpu = rst_n & cpu_req & ~(dma_req & dma_first);
   assign grant_dma = rst_n & dma_req & ~(cpu_req & ~dma_first);

   assign cpu_stall = rst_n & cpu_req & ~grant_cpu;
   assign dma_ready = grant_dma;

   always_comb begin
      mem_read   = 1'b0;
      mem_writeb = 4'b0000;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      if (grant_dma) begin
         mem_read   = ~dma_we;
         mem_writeb = dma_we ? dma_writeb : 4'b0000;
         mem_addr   = dma_addr;
         mem_wdata  = dma_wdata;
      end else if (grant_cpu) begin
         mem_read   = cpu_read;
         mem_writeb = cpu_writeb;
      end
   end

   always_comb begin
      owner_nxt = OWN_NONE;
      if (grant_cpu && cpu_read)
         owner_nxt = OWN_CPU;
      else if (grant_dma && !dma_we)
         owner_nxt = OWN_DMA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 8'd0;
         owner      <= OWN_NONE;
      end else begin
         owner <= owner_nxt;
         if (!dma_req || grant_dma)
            starve_cnt <= 8'd0;
         else if (starve_cnt < SMAX)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

   assign dma_rvalid = (owner == OWN_DMA);
   assign dma_rdata  = mem_rdata;
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed plan steps, then constrained-random
// traffic checked against a transaction-level model with its own memory.
module tb_dmem_arbiter;

   localparam int SM = 4;

   logic        clk;
   logic        rst_n;
   logic        pipe_flush;
   logic        cpu_read;
   logic [3:0]  cpu_writeb;
   logic [10:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        dma_valid;
   logic        dma_ready;
   logic        dma_we;
   logic [3:0]  dma_writeb;
   logic [10:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_read;
   logic [3:0]  mem_writeb;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(.ADDR_W(11), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
      .cpu_read(cpu_read), .cpu_writeb(cpu_writeb),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
      .dma_writeb(dma_writeb), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata), .mem_read(mem_read),
      .mem_writeb(mem_writeb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // environment memory seen by the DUT
   logic [31:0] env_mem [0:2047];
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= env_mem[mem_addr];
      for (int b = 0; b < 4; b++)
         if (mem_writeb[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   // reference model state
   logic [31:0] ref_mem [0:2047];
   int          denied;
   int          pend;
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic rd,
                        input logic [3:0] wb, input logic [10:0] ca,
                        input logic [31:0] cd, input logic dv,
                        input logic dwe, input logic [3:0] dwb,
                        input logic [10:0] da, input logic [31:0] dd);
      pipe_flush = fl;  cpu_read = rd;  cpu_writeb = wb;
      cpu_addr = ca;    cpu_wdata = cd;
      dma_valid = dv;   dma_we = dwe;   dma_writeb = dwb;
      dma_addr = da;    dma_wdata = dd;
   endtask

   // 0 none, 1 CPU, 2 DMA
   function automatic int exp_grant();
      bit creq = (cpu_read || cpu_writeb != 0) && !pipe_flush;
      if (!rst_n) return 0;
      if (creq && dma_valid) return (denied >= SM) ? 2 : 1;
      if (creq) return 1;
      if (dma_valid) return 2;
      return 0;
   endfunction

   task automatic check_cycle(output int g);
      bit creq;
      creq = (cpu_read || cpu_writeb != 0) && !pipe_flush;
      g = exp_grant();
      chk("dma_ready", 32'(dma_ready), 32'(g == 2));
      chk("cpu_stall", 32'(cpu_stall), 32'(rst_n && creq && g != 1));
      chk("mem_read", 32'(mem_read),
          32'(g == 1 ? cpu_read : (g == 2 ? !dma_we : 1'b0)));
      chk("mem_writeb", 32'(mem_writeb),
          32'(g == 1 ? cpu_writeb : ((g == 2 && dma_we) ? dma_writeb : 4'd0)));
      if (g != 0) begin
         chk("mem_addr", 32'(mem_addr), 32'(g == 2 ? dma_addr : cpu_addr));
         chk("mem_wdata", mem_wdata, g == 2 ? dma_wdata : cpu_wdata);
      end
      chk("dma_rvalid", 32'(dma_rvalid), 32'(pend == 2));
      if (pend == 1) chk("cpu_rdata", cpu_rdata, last_rd);
      if (pend == 2) chk("dma_rdata", dma_rdata, last_rd);
   endtask

   task automatic update(input int g);
      logic [10:0] a;
      logic [3:0]  wb;
      logic [31:0] wd;
      bit rd;
      if (!rst_n) begin
         denied = 0;
         pend = 0;
         return;
      end
      a  = (g == 2) ? dma_addr : cpu_addr;
      wd = (g == 2) ? dma_wdata : cpu_wdata;
      wb = (g == 2) ? (dma_we ? dma_writeb : 4'd0) : cpu_writeb;
      rd = (g == 2) ? !dma_we : cpu_read;
      pend = 0;
      if (g != 0 && rd) begin
         last_rd = ref_mem[a];
         pend = g;
      end
      if (g != 0)
         for (int b = 0; b < 4; b++)
            if (wb[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      if (dma_valid && g != 2) denied = (denied + 1 > SM) ? SM : denied + 1;
      else denied = 0;
   endtask

   task automatic step(output int g);
      #3;
      check_cycle(g);
      @(posedge clk);
      #1;
      update(g);
   endtask

   int g;
   logic [3:0]  r_wb, r_dwb;
   logic [10:0] r_ca, r_da;
   logic [31:0] r_cd, r_dd;
   logic        r_rd, r_fl, r_dv, r_dwe;

   initial begin
      for (int i = 0; i < 2048; i++) begin
         env_mem[i] = 32'(i) * 32'h9E3779B1;
         ref_mem[i] = 32'(i) * 32'h9E3779B1;
      end
      denied = 0; pend = 0; last_rd = '0;
      rst_n = 1'b0;
      drive(0, 1, 4'h0, 11'h010, 0, 1, 0, 4'h0, 11'h020, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("rst_dma_ready", 32'(dma_ready), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // CPU load only
      drive(0, 1, 4'h0, 11'h010, 0, 0, 0, 4'h0, 11'h0, 0);
      #3;
      chk("ld_mem_read", 32'(mem_read), 32'd1);
      chk("ld_mem_addr", 32'(mem_addr), 32'h010);
      chk("ld_stall", 32'(cpu_stall), 32'd0);
      step(g);
      drive(0, 0, 4'h0, 11'h0, 0, 0, 0, 4'h0, 11'h0, 0);
      #3;
      chk("ld_rvalid", 32'(dma_rvalid), 32'd0);
      chk("ld_rdata", cpu_rdata, 32'h010 * 32'h9E3779B1);
      step(g);

      // DMA write only
      drive(0, 0, 4'h0, 11'h0, 0, 1, 1, 4'hF, 11'h7FF, 32'hDEADBEEF);
      #3;
      chk("dw_ready", 32'(dma_ready), 32'd1);
      chk("dw_writeb", 32'(mem_writeb), 32'hF);
      chk("dw_wdata", mem_wdata, 32'hDEADBEEF);
      step(g);

      // contention: period-5 pattern, DMA on every fifth cycle
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 4'h0, 11'(i), 0, 1, 1, 4'h3, 11'h100, 32'(i));
         #3;
         chk("ct_ready", 32'(dma_ready), 32'(i % 5 == 4));
         chk("ct_stall", 32'(cpu_stall), 32'(i % 5 == 4));
         step(g);
      end

      // flushed store with no DMA
      drive(1, 0, 4'h3, 11'h055, 32'h12345678, 0, 0, 4'h0, 11'h0, 0);
      #3;
      chk("fl_writeb", 32'(mem_writeb), 32'd0);
      chk("fl_stall", 32'(cpu_stall), 32'd0);
      step(g);

      // flush with DMA request: DMA granted
      drive(1, 1, 4'h0, 11'h055, 0, 1, 0, 4'h0, 11'h004, 0);
      step(g);

      // alternating DMA read then CPU read
      drive(0, 0, 4'h0, 11'h0, 0, 1, 0, 4'h0, 11'h004, 0);
      step(g);
      drive(0, 1, 4'h0, 11'h008, 0, 0, 0, 4'h0, 11'h0, 0);
      #3;
      chk("alt_rvalid1", 32'(dma_rvalid), 32'd1);
      chk("alt_rdata1", dma_rdata, 32'h004 * 32'h9E3779B1);
      step(g);
      drive(0, 0, 4'h0, 11'h0, 0, 0, 0, 4'h0, 11'h0, 0);
      #3;
      chk("alt_rvalid2", 32'(dma_rvalid), 32'd0);
      chk("alt_rdata2", cpu_rdata, 32'h008 * 32'h9E3779B1);
      step(g);

      // reset with a DMA read in flight
      drive(0, 0, 4'h0, 11'h0, 0, 1, 0, 4'h0, 11'h030, 0);
      #3;
      chk("rr_ready", 32'(dma_ready), 32'd1);
      rst_n = 1'b0;
      denied = 0; pend = 0;
      #1;
      chk("rr_ready_rst", 32'(dma_ready), 32'd0);
      @(posedge clk); #1;
      drive(0, 1, 4'h0, 11'h031, 0, 1, 0, 4'h0, 11'h030, 0);
      for (int i = 0; i < 2; i++) step(g);
      rst_n = 1'b1;
      for (int i = 0; i < SM + 2; i++) step(g);

      // constrained-random traffic, requesters hold while stalled
      r_fl = 0; r_rd = 0; r_wb = 0; r_ca = 0; r_cd = 0;
      r_dv = 0; r_dwe = 0; r_dwb = 0; r_da = 0; r_dd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!cpu_stall) begin
            r_fl = ($urandom_range(0, 7) == 0);
            r_rd = $urandom_range(0, 1) == 1;
            r_wb = r_rd ? 4'h0 : 4'($urandom_range(0, 15));
            r_ca = 11'($urandom_range(0, 15));
            r_cd = $urandom;
         end
         if (!dma_valid || dma_ready) begin
            r_dv = $urandom_range(0, 2) != 0;
            r_dwe = $urandom_range(0, 1) == 1;
            r_dwb = 4'($urandom_range(0, 15));
            r_da = 11'($urandom_range(0, 15));
            r_dd = $urandom;
         end
         drive(r_fl, r_rd, r_wb, r_ca, r_cd, r_dv, r_dwe, r_dwb, r_da, r_dd);
         step(g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
